// File: rtl/regfile_param_if.sv
// regfile_param_if: bus bundle between the datapath controller and the
// register file.
//   master : controller side. Drives write data/enable/address, both read
//            enables/addresses and CLR. Observes Q0/Q1, V0/V1, WR_ACK, BUSY.
//   slave  : register file side, with the directions reversed.
interface regfile_param_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 2
);
  logic [DATA_W-1:0] D;
  logic              ENW;
  logic [ADDR_W-1:0] WRA;
  logic              ENR0;
  logic [ADDR_W-1:0] RDA0;
  logic              ENR1;
  logic [ADDR_W-1:0] RDA1;
  logic              CLR;
  logic [DATA_W-1:0] Q0;
  logic [DATA_W-1:0] Q1;
  logic              V0;
  logic              V1;
  logic              WR_ACK;
  logic              BUSY;

  modport master (
    output D, ENW, WRA, ENR0, RDA0, ENR1, RDA1, CLR,
    input  Q0, Q1, V0, V1, WR_ACK, BUSY
  );

  modport slave (
    input  D, ENW, WRA, ENR0, RDA0, ENR1, RDA1, CLR,
    output Q0, Q1, V0, V1, WR_ACK, BUSY
  );
endinterface

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with per-register valid bits,
// optional write-to-read bypass and a sequenced clear sweep.
// Ports:
//   CLKb : clock; all state changes on its falling edge
//   RST  : asynchronous active-high reset
//   bus  : regfile_param_if.slave (write port, two read ports, CLR,
//          WR_ACK, BUSY)
//
// Clear FSM:
//   state | meaning
//   IDLE  | normal operation, writes accepted, BUSY=0
//   SWEEP | one register cleared per edge from ptr 0 upward, writes dropped
module regfile_param #(
  parameter int                 DATA_W    = 10,
  parameter int                 NUM_REGS  = 4,
  parameter int                 BYPASS    = 1,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic           CLKb,
  input  logic           RST,
  regfile_param_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;
  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] valid;
  logic                accepted;

  assign bus.BUSY   = (state == SWEEP);
  assign accepted   = bus.ENW & ~bus.BUSY;
  assign bus.WR_ACK = accepted;

  always_ff @(negedge CLKb or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (bus.CLR) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        // ptr wraps to 0 naturally after the last register.
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == ADDR_W'(NUM_REGS - 1)) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  // A write accepted on the same edge that sees CLR still lands, since
  // the FSM is still IDLE on that edge.
  always_ff @(negedge CLKb or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
      valid <= '0;
    end else if (state == SWEEP) begin
      mem[ptr]   <= RESET_VAL;
      valid[ptr] <= 1'b0;
    end else if (accepted) begin
      mem[bus.WRA]   <= bus.D;
      valid[bus.WRA] <= 1'b1;
    end
  end

  always_comb begin
    bus.Q0 = '0;
    bus.V0 = 1'b0;
    if (bus.ENR0) begin
      if (BYPASS != 0 && accepted && bus.WRA == bus.RDA0) begin
        bus.Q0 = bus.D;
        bus.V0 = 1'b1;
      end else begin
        bus.Q0 = mem[bus.RDA0];
        bus.V0 = valid[bus.RDA0];
      end
    end
  end

  always_comb begin
    bus.Q1 = '0;
    bus.V1 = 1'b0;
    if (bus.ENR1) begin
      if (BYPASS != 0 && accepted && bus.WRA == bus.RDA1) begin
        bus.Q1 = bus.D;
        bus.V1 = 1'b1;
      end else begin
        bus.Q1 = mem[bus.RDA1];
        bus.V1 = valid[bus.RDA1];
      end
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: drives two register files from one stimulus stream
// (4x10 with bypass, 8x16 without bypass and RESET_VAL=A5A5) and checks
// them against a per-instance array model every cycle, plus literal
// expectations along the directed sequence.
module tb_regfile_param;
  logic        CLKb = 1'b1;
  logic        rst  = 1'b1;
  logic [15:0] s_d  = '0;
  logic        s_enw = 0, s_enr0 = 0, s_enr1 = 0, s_clr = 0;
  logic [2:0]  s_wra = '0, s_rda0 = '0, s_rda1 = '0;
  int          total = 0, bad = 0;

  always #5 CLKb = ~CLKb;

  regfile_param_if #(.DATA_W(10), .ADDR_W(2)) ifa ();
  regfile_param_if #(.DATA_W(16), .ADDR_W(3)) ifb ();

  assign ifa.D = s_d[9:0];   assign ifa.ENW = s_enw;  assign ifa.WRA = s_wra[1:0];
  assign ifa.ENR0 = s_enr0;  assign ifa.RDA0 = s_rda0[1:0];
  assign ifa.ENR1 = s_enr1;  assign ifa.RDA1 = s_rda1[1:0];
  assign ifa.CLR = s_clr;
  assign ifb.D = s_d;        assign ifb.ENW = s_enw;  assign ifb.WRA = s_wra;
  assign ifb.ENR0 = s_enr0;  assign ifb.RDA0 = s_rda0;
  assign ifb.ENR1 = s_enr1;  assign ifb.RDA1 = s_rda1;
  assign ifb.CLR = s_clr;

  regfile_param #(.DATA_W(10), .NUM_REGS(4), .BYPASS(1), .RESET_VAL(10'h000))
    dut_a (.CLKb(CLKb), .RST(rst), .bus(ifa.slave));
  regfile_param #(.DATA_W(16), .NUM_REGS(8), .BYPASS(0), .RESET_VAL(16'hA5A5))
    dut_b (.CLKb(CLKb), .RST(rst), .bus(ifb.slave));

  // ---------------- model ----------------
  logic [15:0] mmem [2][8];
  bit          mval [2][8];
  bit          mbusy [2];
  int          mleft [2];   // registers still to clear in the current sweep

  function automatic int nr(int c);            return (c == 0) ? 4 : 8; endfunction
  function automatic logic [15:0] rv(int c);   return (c == 0) ? 16'h0000 : 16'hA5A5; endfunction
  function automatic logic [15:0] dm(int c);   return (c == 0) ? 16'h03FF : 16'hFFFF; endfunction
  function automatic bit byp(int c);           return (c == 0); endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 8; i++) begin
        mmem[c][i] = rv(c);
        mval[c][i] = 0;
      end
      mbusy[c] = 0;
      mleft[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      if (mbusy[c]) begin
        int k = nr(c) - mleft[c];
        mmem[c][k] = rv(c);
        mval[c][k] = 0;
        mleft[c]--;
        if (mleft[c] == 0) mbusy[c] = 0;
      end else begin
        if (s_enw) begin
          mmem[c][int'(s_wra) % nr(c)] = s_d & dm(c);
          mval[c][int'(s_wra) % nr(c)] = 1;
        end
        if (s_clr) begin
          mbusy[c] = 1;
          mleft[c] = nr(c);
        end
      end
    end
  endtask

  always @(negedge CLKb or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  function automatic bit hit(int c, logic [2:0] ra);
    return byp(c) && s_enw && !mbusy[c] && (int'(s_wra) % nr(c)) == (int'(ra) % nr(c));
  endfunction

  function automatic logic [15:0] eq(int c, logic en, logic [2:0] ra);
    if (!en) return 16'h0;
    if (hit(c, ra)) return s_d & dm(c);
    return mmem[c][int'(ra) % nr(c)];
  endfunction

  function automatic logic [15:0] ev(int c, logic en, logic [2:0] ra);
    if (!en) return 16'h0;
    if (hit(c, ra)) return 16'h1;
    return {15'h0, mval[c][int'(ra) % nr(c)]};
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // compare process: mid high phase, well clear of the falling edge
  always @(posedge CLKb) begin
    #3;
    chk("a_q0", {6'h0, ifa.Q0}, eq(0, s_enr0, s_rda0));
    chk("a_v0", {15'h0, ifa.V0}, ev(0, s_enr0, s_rda0));
    chk("a_q1", {6'h0, ifa.Q1}, eq(0, s_enr1, s_rda1));
    chk("a_v1", {15'h0, ifa.V1}, ev(0, s_enr1, s_rda1));
    chk("a_ack", {15'h0, ifa.WR_ACK}, {15'h0, s_enw & ~mbusy[0]});
    chk("a_busy", {15'h0, ifa.BUSY}, {15'h0, mbusy[0]});
    chk("b_q0", ifb.Q0, eq(1, s_enr0, s_rda0));
    chk("b_v0", {15'h0, ifb.V0}, ev(1, s_enr0, s_rda0));
    chk("b_q1", ifb.Q1, eq(1, s_enr1, s_rda1));
    chk("b_v1", {15'h0, ifb.V1}, ev(1, s_enr1, s_rda1));
    chk("b_ack", {15'h0, ifb.WR_ACK}, {15'h0, s_enw & ~mbusy[1]});
    chk("b_busy", {15'h0, ifb.BUSY}, {15'h0, mbusy[1]});
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLKb);
    #1;
  endtask

  task automatic wr(logic [2:0] a, logic [15:0] d);
    cyc();
    s_enw = 1; s_wra = a; s_d = d; s_clr = 0;
    #1 chk("wr_ack", {15'h0, ifa.WR_ACK}, 16'h1);
  endtask

  logic [9:0] fv [4];
  int na, nb;

  initial begin
    fv[0] = 10'h111; fv[1] = 10'h222; fv[2] = 10'h333; fv[3] = 10'h044;
    repeat (3) cyc();
    rst = 0;

    // reset state on every address
    for (int i = 0; i < 4; i++) begin
      cyc();
      s_enr0 = 1; s_enr1 = 1; s_rda0 = 3'(i); s_rda1 = 3'(3 - i);
      #1;
      chk("rst_a_q0", {6'h0, ifa.Q0}, 16'h0);
      chk("rst_a_v0", {15'h0, ifa.V0}, 16'h0);
      chk("rst_a_q1", {6'h0, ifa.Q1}, 16'h0);
      chk("rst_a_v1", {15'h0, ifa.V1}, 16'h0);
      chk("rst_b_q0", ifb.Q0, 16'hA5A5);
    end

    // write / readback
    wr(3'd2, 16'h0155);
    wr(3'd3, 16'h02AA);
    cyc();
    s_enw = 0; s_rda0 = 3'd2; s_rda1 = 3'd3;
    #1;
    chk("rb_q0", {6'h0, ifa.Q0}, 16'h0155);
    chk("rb_q1", {6'h0, ifa.Q1}, 16'h02AA);
    chk("rb_v0", {15'h0, ifa.V0}, 16'h1);
    chk("rb_v1", {15'h0, ifa.V1}, 16'h1);

    // bypass (a) vs no bypass (b)
    cyc();
    s_enw = 1; s_wra = 3'd1; s_d = 16'h00F0; s_enr0 = 1; s_rda0 = 3'd1;
    #1;
    chk("byp_a_q0", {6'h0, ifa.Q0}, 16'h00F0);
    chk("byp_a_v0", {15'h0, ifa.V0}, 16'h1);
    chk("nobyp_b_q0", ifb.Q0, 16'hA5A5);
    chk("nobyp_b_v0", {15'h0, ifb.V0}, 16'h0);
    cyc();
    s_enw = 0;
    #1;
    chk("nobyp_b_q0_after", ifb.Q0, 16'h00F0);
    chk("nobyp_b_v0_after", {15'h0, ifb.V0}, 16'h1);

    // read disable
    wr(3'd0, 16'h03FF);
    cyc();
    s_enw = 0; s_enr0 = 0; s_rda0 = 3'd0; s_enr1 = 1; s_rda1 = 3'd0;
    #1;
    chk("dis_q0", {6'h0, ifa.Q0}, 16'h0);
    chk("dis_v0", {15'h0, ifa.V0}, 16'h0);
    chk("dis_q1", {6'h0, ifa.Q1}, 16'h03FF);
    chk("dis_v1", {15'h0, ifa.V1}, 16'h1);

    // clear sweep
    for (int i = 0; i < 4; i++) wr(3'(i), {6'h0, fv[i]});
    cyc();
    s_enw = 0; s_clr = 1; s_enr0 = 1; s_enr1 = 1;
    na = 0; nb = 0;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      s_clr = 0; s_enw = 0;
      if (j == 2) begin s_rda0 = 3'd0; s_rda1 = 3'd3; end
      if (j == 3) begin
        s_rda0 = 3'd1; s_rda1 = 3'd2;
        s_enw = 1; s_wra = 3'd0; s_d = 16'h03FF; s_clr = 1;
      end
      #1;
      if (ifa.BUSY) na++;
      if (ifb.BUSY) nb++;
      if (j == 2) begin
        chk("sw2_q0", {6'h0, ifa.Q0}, 16'h0);
        chk("sw2_v0", {15'h0, ifa.V0}, 16'h0);
        chk("sw2_q1", {6'h0, ifa.Q1}, {6'h0, fv[3]});
      end
      if (j == 3) begin
        chk("sw3_q0", {6'h0, ifa.Q0}, 16'h0);
        chk("sw3_v0", {15'h0, ifa.V0}, 16'h0);
        chk("sw3_q1", {6'h0, ifa.Q1}, {6'h0, fv[2]});
        chk("sw3_v1", {15'h0, ifa.V1}, 16'h1);
        chk("sw3_ack", {15'h0, ifa.WR_ACK}, 16'h0);
      end
    end
    chk("busy_len_a", 16'(na), 16'd4);
    chk("busy_len_b", 16'(nb), 16'd8);
    for (int i = 0; i < 8; i++) begin
      cyc();
      s_rda0 = 3'(i); s_rda1 = 3'(i);
      #1;
      if (i < 4) begin
        chk("post_a_q0", {6'h0, ifa.Q0}, 16'h0);
        chk("post_a_v1", {15'h0, ifa.V1}, 16'h0);
      end
      chk("post_b_q0", ifb.Q0, 16'hA5A5);
      chk("post_b_v0", {15'h0, ifb.V0}, 16'h0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      s_d    = 16'($urandom);
      s_enw  = 1'($urandom_range(0, 1));
      s_wra  = 3'($urandom);
      s_enr0 = ($urandom_range(0, 3) != 0);
      s_enr1 = ($urandom_range(0, 3) != 0);
      s_rda0 = 3'($urandom);
      s_rda1 = 3'($urandom);
      s_clr  = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 199) == 0);
    end
    rst = 0;

    // async reset in the middle of a sweep
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1234 + 16'(i));
    cyc();
    s_enw = 0; s_clr = 1;
    cyc();
    s_clr = 0;
    cyc();
    #1 chk("pre_rst_busy", {15'h0, ifb.BUSY}, 16'h1);
    rst = 1;
    #1;
    chk("mid_rst_busy_a", {15'h0, ifa.BUSY}, 16'h0);
    chk("mid_rst_busy_b", {15'h0, ifb.BUSY}, 16'h0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      s_enr0 = 1; s_rda0 = 3'(i); s_enr1 = 1; s_rda1 = 3'(7 - i);
      #1;
      if (i < 4) begin
        chk("mrst_a_q0", {6'h0, ifa.Q0}, 16'h0);
        chk("mrst_a_v0", {15'h0, ifa.V0}, 16'h0);
      end
      chk("mrst_b_q0", ifb.Q0, 16'hA5A5);
      chk("mrst_b_v0", {15'h0, ifb.V0}, 16'h0);
    end
    cyc();
    rst = 0;
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
